drive_sequencer: RTL and testbench
==================================

// Module: drive_sequencer
// PURPOSE
//  Line-follow drive controller for the car. Takes the 3-bit tracker state {left,mid,right}
//  and the ultrasonic obstacle flag, and sequences the two motors through a state machine:
//  follow, blocked, lost-line search and fault halt.
//  Drives motor direction pins plus the 10-bit duties that feed the per-wheel PWM generators.
// PARAMETERS
//  CLK_PER_MS  100_000  clk cycles per 1 ms tick
//  SEARCH_MS   1500     max pivot time hunting a lost line before FAULT
//  CLEAR_MS    500      obstacle must stay clear this long before resuming
//  DUTY_FAST   1023     duty for straight / outer wheel
//  DUTY_SLOW   800      duty for search pivot wheels
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-high reset
//  enable     in   1   run request (level); low forces IDLE
//  sensor     in   3   {left,mid,right} tracker bits, 1 = on line, asynchronous
//  obstacle   in   1   1 = object closer than stop distance, asynchronous
//  left_dir   out  2   2'b00 stop, 2'b01 forward, 2'b10 backward
//  right_dir  out  2   same encoding as left_dir
//  left_duty  out  10  PWM duty, left wheel
//  right_duty out  10  PWM duty, right wheel
//  state_dbg  out  3   current state encoding (for LEDs)
// BEHAVIOUR
//  - Reset: all flops clear; state IDLE; dirs 2'b00; duties 0; last_side LEFT; timers 0.
//  - sensor and obstacle each pass through a 2-flop synchronizer. All outputs are registered.
//    An input change reaches the outputs in <= 3 clk.
//  - ms_tick: 1-clk pulse every CLK_PER_MS cycles from a free-running counter.
//    ms_timer clears on every state change and increments on ms_tick, saturating at 2^16-1.
//  - States: IDLE=0, FOLLOW=1, BLOCKED=2, SEARCH=3, FAULT=4.
//  - Transition priority, highest first: reset > !enable (-> IDLE) > obstacle > timer > sensor.
//  - IDLE: stop. enable=1 -> FOLLOW.
//  - FOLLOW:
//      111/010/101 -> both fwd, DUTY_FAST.
//      110/100 -> left stop/0, right fwd FAST; last_side<=LEFT.
//      011/001 -> left fwd FAST, right stop/0; last_side<=RIGHT.
//      000 -> SEARCH.
//  - SEARCH: pivot toward last_side at DUTY_SLOW.
//      LEFT: left bwd, right fwd. RIGHT: mirrored.
//      Any sensor bit set -> FOLLOW. ms_timer reaching SEARCH_MS -> FAULT.
//  - BLOCKED: both stop, duty 0. Entered from FOLLOW or SEARCH when obstacle=1.
//      ms_timer clears on every cycle obstacle=1. ms_timer reaching CLEAR_MS -> FOLLOW.
//  - FAULT: both stop. Leaves only via enable=0 (-> IDLE).
//  - Obstacle in IDLE/FAULT is ignored. Obstacle and a 000 sensor in the same cycle -> BLOCKED.
//  - enable dropping mid-SEARCH/BLOCKED -> IDLE next clk; timers clear.
//  - Reset asserted mid-operation: outputs stop asynchronously.
//  - Outputs never drive dir 2'b11.
// TESTING
//  Params CLK_PER_MS=10, SEARCH_MS=5, CLEAR_MS=3.
//  1. reset, enable=1, sensor=111 -> within 3 clk: dirs 01/01, duties 1023/1023, state_dbg=1.
//  2. sensor 110 then 000 -> turn-left outputs (00/01, 0/1023), then SEARCH pivot
//     left (10/01, 800/800). Sensor held 000 for 50 clk -> FAULT, dirs 00/00.
//     Then enable=0 -> IDLE.
//  3. FOLLOW, obstacle=1 -> BLOCKED, duties 0 within 3 clk.
//     Obstacle pulses low 20 clk then high again -> stays BLOCKED.
//     Low 30 clk -> FOLLOW.
//  4. SEARCH via last_side RIGHT, sensor 001 returns after 2 ms -> FOLLOW with 01/00, 1023/0.
//  5. Assert reset asynchronously mid-FOLLOW -> dirs 00, duties 0 before next clk edge;
//     state_dbg=0.
//  6. enable=0 while obstacle=1 and sensor=000 -> IDLE (enable priority).

Source files
------------

// File: rtl/drive_sequencer.sv
// Line-follow drive controller: synchronizes tracker/obstacle inputs and sequences the two
// motors through follow, blocked, lost-line search and fault states with registered outputs.
module drive_sequencer #(
    parameter int CLK_PER_MS = 100_000,
    parameter int SEARCH_MS  = 1500,
    parameter int CLEAR_MS   = 500,
    parameter int DUTY_FAST  = 1023,
    parameter int DUTY_SLOW  = 800
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] sensor,
    input  logic       obstacle,
    output logic [1:0] left_dir,
    output logic [1:0] right_dir,
    output logic [9:0] left_duty,
    output logic [9:0] right_duty,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FOLLOW  = 3'd1,
        BLOCKED = 3'd2,
        SEARCH  = 3'd3,
        FAULT   = 3'd4
    } state_t;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_FWD  = 2'b01;
    localparam logic [1:0] DIR_BWD  = 2'b10;
    localparam logic       SIDE_LEFT  = 1'b0;
    localparam logic       SIDE_RIGHT = 1'b1;
    localparam int         CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    logic [2:0]    sensor_meta_q, sensor_sync_q;
    logic          obstacle_meta_q, obstacle_sync_q;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic          ms_tick;
    logic [15:0]   ms_timer_q, ms_timer_d;
    state_t        state_q, state_d;
    logic          last_side_q, last_side_d;
    logic [1:0]    left_dir_q, left_dir_d, right_dir_q, right_dir_d;
    logic [9:0]    left_duty_q, left_duty_d, right_duty_q, right_duty_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sensor_meta_q   <= '0;
            sensor_sync_q   <= '0;
            obstacle_meta_q <= 1'b0;
            obstacle_sync_q <= 1'b0;
        end else begin
            sensor_meta_q   <= sensor;
            sensor_sync_q   <= sensor_meta_q;
            obstacle_meta_q <= obstacle;
            obstacle_sync_q <= obstacle_meta_q;
        end
    end

    assign ms_tick = (tick_cnt_q == CW'(CLK_PER_MS - 1));

    always_comb begin
        tick_cnt_d = ms_tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Enable outranks everything; within a state, obstacle outranks the timer, which outranks sensor.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = FOLLOW;
                FOLLOW: begin
                    if (obstacle_sync_q)           state_d = BLOCKED;
                    else if (sensor_sync_q == 3'b000) state_d = SEARCH;
                end
                SEARCH: begin
                    if (obstacle_sync_q)                    state_d = BLOCKED;
                    else if (ms_timer_q >= 16'(SEARCH_MS))  state_d = FAULT;
                    else if (sensor_sync_q != 3'b000)       state_d = FOLLOW;
                end
                BLOCKED: begin
                    if (!obstacle_sync_q && ms_timer_q >= 16'(CLEAR_MS)) state_d = FOLLOW;
                end
                FAULT:   state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ms_timer_d = ms_timer_q;
        if (state_d != state_q || (state_q == BLOCKED && obstacle_sync_q)) begin
            ms_timer_d = '0;
        end else if (ms_tick && ms_timer_q != 16'hFFFF) begin
            ms_timer_d = ms_timer_q + 16'd1;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as state_q.
    always_comb begin
        last_side_d  = last_side_q;
        left_dir_d   = DIR_STOP;
        right_dir_d  = DIR_STOP;
        left_duty_d  = '0;
        right_duty_d = '0;
        unique case (state_d)
            FOLLOW: begin
                unique case (sensor_sync_q)
                    3'b111, 3'b010, 3'b101: begin
                        left_dir_d   = DIR_FWD;
                        right_dir_d  = DIR_FWD;
                        left_duty_d  = 10'(DUTY_FAST);
                        right_duty_d = 10'(DUTY_FAST);
                    end
                    3'b110, 3'b100: begin
                        right_dir_d  = DIR_FWD;
                        right_duty_d = 10'(DUTY_FAST);
                        last_side_d  = SIDE_LEFT;
                    end
                    3'b011, 3'b001: begin
                        left_dir_d   = DIR_FWD;
                        left_duty_d  = 10'(DUTY_FAST);
                        last_side_d  = SIDE_RIGHT;
                    end
                    default: ;
                endcase
            end
            SEARCH: begin
                left_dir_d   = (last_side_q == SIDE_LEFT) ? DIR_BWD : DIR_FWD;
                right_dir_d  = (last_side_q == SIDE_LEFT) ? DIR_FWD : DIR_BWD;
                left_duty_d  = 10'(DUTY_SLOW);
                right_duty_d = 10'(DUTY_SLOW);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q   <= '0;
            ms_timer_q   <= '0;
            state_q      <= IDLE;
            last_side_q  <= SIDE_LEFT;
            left_dir_q   <= DIR_STOP;
            right_dir_q  <= DIR_STOP;
            left_duty_q  <= '0;
            right_duty_q <= '0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            ms_timer_q   <= ms_timer_d;
            state_q      <= state_d;
            last_side_q  <= last_side_d;
            left_dir_q   <= left_dir_d;
            right_dir_q  <= right_dir_d;
            left_duty_q  <= left_duty_d;
            right_duty_q <= right_duty_d;
        end
    end

    assign left_dir   = left_dir_q;
    assign right_dir  = right_dir_q;
    assign left_duty  = left_duty_q;
    assign right_duty = right_duty_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer with shortened timing (10 clk/ms, search 5 ms, clear 3 ms).
// Each check compares {left_dir, right_dir, left_duty, right_duty, state_dbg} as one vector.
module tb_drive_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] sensor;
    logic       obstacle;
    logic [1:0] left_dir, right_dir;
    logic [9:0] left_duty, right_duty;
    logic [2:0] state_dbg;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [26:0] observed;

    drive_sequencer #(
        .CLK_PER_MS(10),
        .SEARCH_MS (5),
        .CLEAR_MS  (3),
        .DUTY_FAST (1023),
        .DUTY_SLOW (800)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .sensor    (sensor),
        .obstacle  (obstacle),
        .left_dir  (left_dir),
        .right_dir (right_dir),
        .left_duty (left_duty),
        .right_duty(right_duty),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    assign observed = {left_dir, right_dir, left_duty, right_duty, state_dbg};

    localparam logic [26:0] V_IDLE     = {2'b00, 2'b00, 10'd0,    10'd0,    3'd0};
    localparam logic [26:0] V_STRAIGHT = {2'b01, 2'b01, 10'd1023, 10'd1023, 3'd1};
    localparam logic [26:0] V_TURN_L   = {2'b00, 2'b01, 10'd0,    10'd1023, 3'd1};
    localparam logic [26:0] V_TURN_R   = {2'b01, 2'b00, 10'd1023, 10'd0,    3'd1};
    localparam logic [26:0] V_SRCH_L   = {2'b10, 2'b01, 10'd800,  10'd800,  3'd3};
    localparam logic [26:0] V_SRCH_R   = {2'b01, 2'b10, 10'd800,  10'd800,  3'd3};
    localparam logic [26:0] V_BLOCKED  = {2'b00, 2'b00, 10'd0,    10'd0,    3'd2};
    localparam logic [26:0] V_FAULT    = {2'b00, 2'b00, 10'd0,    10'd0,    3'd4};

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; sensor = 3'b000; obstacle = 1'b0;
        wait_clk(2);
        total_cnt++;
        if (observed !== V_IDLE) $display("[TB] FAIL reset_state got=%h exp=%h", observed, V_IDLE);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_follow_straight();
        sensor = 3'b111;
        wait_clk(3);
        enable = 1'b1;
        wait_clk(3);
        total_cnt++;
        if (observed !== V_STRAIGHT) $display("[TB] FAIL follow_straight got=%h exp=%h", observed, V_STRAIGHT);
        else pass_cnt++;
    endtask

    task automatic test_search_fault();
        sensor = 3'b110;
        wait_clk(3);
        total_cnt++;
        if (observed !== V_TURN_L) $display("[TB] FAIL turn_left got=%h exp=%h", observed, V_TURN_L);
        else pass_cnt++;
        sensor = 3'b000;
        wait_clk(3);
        total_cnt++;
        if (observed !== V_SRCH_L) $display("[TB] FAIL search_left got=%h exp=%h", observed, V_SRCH_L);
        else pass_cnt++;
        wait_clk(27);
        total_cnt++;
        if (observed !== V_SRCH_L) $display("[TB] FAIL search_before_timeout got=%h exp=%h", observed, V_SRCH_L);
        else pass_cnt++;
        wait_clk(30);
        total_cnt++;
        if (observed !== V_FAULT) $display("[TB] FAIL search_timeout_fault got=%h exp=%h", observed, V_FAULT);
        else pass_cnt++;
        enable = 1'b0;
        wait_clk(1);
        total_cnt++;
        if (observed !== V_IDLE) $display("[TB] FAIL fault_to_idle got=%h exp=%h", observed, V_IDLE);
        else pass_cnt++;
    endtask

    task automatic test_blocked();
        sensor = 3'b111;
        wait_clk(3);
        enable = 1'b1;
        wait_clk(3);
        total_cnt++;
        if (observed !== V_STRAIGHT) $display("[TB] FAIL refollow got=%h exp=%h", observed, V_STRAIGHT);
        else pass_cnt++;
        obstacle = 1'b1;
        wait_clk(3);
        total_cnt++;
        if (observed !== V_BLOCKED) $display("[TB] FAIL blocked_entry got=%h exp=%h", observed, V_BLOCKED);
        else pass_cnt++;
        obstacle = 1'b0;
        wait_clk(20);
        obstacle = 1'b1;
        wait_clk(5);
        total_cnt++;
        if (observed !== V_BLOCKED) $display("[TB] FAIL blocked_short_clear got=%h exp=%h", observed, V_BLOCKED);
        else pass_cnt++;
        obstacle = 1'b0;
        wait_clk(40);
        total_cnt++;
        if (observed !== V_STRAIGHT) $display("[TB] FAIL blocked_resume got=%h exp=%h", observed, V_STRAIGHT);
        else pass_cnt++;
    endtask

    task automatic test_search_right();
        sensor = 3'b011;
        wait_clk(3);
        total_cnt++;
        if (observed !== V_TURN_R) $display("[TB] FAIL turn_right got=%h exp=%h", observed, V_TURN_R);
        else pass_cnt++;
        sensor = 3'b000;
        wait_clk(3);
        total_cnt++;
        if (observed !== V_SRCH_R) $display("[TB] FAIL search_right got=%h exp=%h", observed, V_SRCH_R);
        else pass_cnt++;
        wait_clk(17);
        sensor = 3'b001;
        wait_clk(3);
        total_cnt++;
        if (observed !== V_TURN_R) $display("[TB] FAIL search_recover got=%h exp=%h", observed, V_TURN_R);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        reset = 1'b1;
        #1;
        total_cnt++;
        if (observed !== V_IDLE) $display("[TB] FAIL async_reset got=%h exp=%h", observed, V_IDLE);
        else pass_cnt++;
        wait_clk(1);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        sensor = 3'b111;
        wait_clk(5);
        total_cnt++;
        if (observed !== V_STRAIGHT) $display("[TB] FAIL post_reset_follow got=%h exp=%h", observed, V_STRAIGHT);
        else pass_cnt++;
        obstacle = 1'b1;
        sensor   = 3'b000;
        wait_clk(4);
        total_cnt++;
        if (observed !== V_BLOCKED) $display("[TB] FAIL obstacle_over_lost got=%h exp=%h", observed, V_BLOCKED);
        else pass_cnt++;
        enable = 1'b0;
        wait_clk(1);
        total_cnt++;
        if (observed !== V_IDLE) $display("[TB] FAIL blocked_disable got=%h exp=%h", observed, V_IDLE);
        else pass_cnt++;
        wait_clk(4);
        total_cnt++;
        if (observed !== V_IDLE) $display("[TB] FAIL enable_priority got=%h exp=%h", observed, V_IDLE);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_follow_straight();
        test_search_fault();
        test_blocked();
        test_search_right();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
